// File: rtl/sincos_phase_gen.sv
// sincos_phase_gen: programmable NCO phase generator feeding sincos_linear.
// Double-buffered config keeps frequency changes phase-continuous mid-run.
module sincos_phase_gen #(
    parameter int COUNT_WIDTH = 16,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cfg_we,
    input  logic [31:0]            cfg_freq,
    input  logic [31:0]            cfg_offset,
    input  logic [DIV_WIDTH-1:0]   cfg_div,
    input  logic [COUNT_WIDTH-1:0] cfg_burst,
    input  logic                   start,
    input  logic                   stop,
    output logic [31:0]            phase_o,
    output logic                   valid_o,
    output logic                   busy_o,
    output logic                   done_o
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]             r_state;
    logic [31:0]            r_freq_sh, r_offset_sh, r_freq_a, r_offset_a, r_acc, r_phase;
    logic [DIV_WIDTH-1:0]   r_div_sh, r_div_a, r_divcnt;
    logic [COUNT_WIDTH-1:0] r_burst_sh, r_burst_a, r_scnt;
    logic                   r_pend, r_valid, r_done;

    logic                   w_sample, w_last, w_stop;
    logic [COUNT_WIDTH-1:0] w_scnt_nxt;

    assign w_scnt_nxt = r_scnt + COUNT_WIDTH'(1);
    assign w_sample   = (r_state == S_RUN) && (r_divcnt == '0);
    assign w_last     = w_sample && (r_burst_a != '0) && (w_scnt_nxt == r_burst_a);
    // A stop on the final burst sample edge loses to the burst completion.
    assign w_stop     = (r_state == S_RUN) && stop && !w_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_freq_sh   <= '0;
            r_offset_sh <= '0;
            r_div_sh    <= '0;
            r_burst_sh  <= '0;
            r_freq_a    <= '0;
            r_offset_a  <= '0;
            r_div_a     <= '0;
            r_burst_a   <= '0;
            r_acc       <= '0;
            r_divcnt    <= '0;
            r_scnt      <= '0;
            r_pend      <= 1'b0;
            r_phase     <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (cfg_we) begin
                r_freq_sh   <= cfg_freq;
                r_offset_sh <= cfg_offset;
                r_div_sh    <= cfg_div;
                r_burst_sh  <= cfg_burst;
            end
            if (r_state == S_IDLE) begin
                r_valid <= 1'b0;
                r_done  <= 1'b0;
                if (start) begin
                    r_freq_a   <= cfg_we ? cfg_freq   : r_freq_sh;
                    r_offset_a <= cfg_we ? cfg_offset : r_offset_sh;
                    r_div_a    <= cfg_we ? cfg_div    : r_div_sh;
                    r_burst_a  <= cfg_we ? cfg_burst  : r_burst_sh;
                    r_acc      <= '0;
                    r_divcnt   <= '0;
                    r_scnt     <= '0;
                    r_pend     <= 1'b0;
                    r_state    <= S_RUN;
                end
            end else if (w_stop) begin
                r_valid <= 1'b0;
                r_done  <= 1'b0;
                r_state <= S_IDLE;
            end else if (w_sample) begin
                r_phase  <= r_acc + r_offset_a;
                r_valid  <= 1'b1;
                r_acc    <= r_acc + r_freq_a;
                r_scnt   <= w_scnt_nxt;
                r_divcnt <= r_pend ? r_div_sh : r_div_a;
                if (r_pend) begin
                    r_freq_a   <= r_freq_sh;
                    r_offset_a <= r_offset_sh;
                    r_div_a    <= r_div_sh;
                end
                // A write on this very edge stays pending for the next sample.
                r_pend   <= cfg_we;
                r_done   <= w_last;
                if (w_last) r_state <= S_IDLE;
            end else begin
                r_divcnt <= r_divcnt - DIV_WIDTH'(1);
                r_valid  <= 1'b0;
                r_done   <= 1'b0;
                r_pend   <= r_pend | cfg_we;
            end
        end
    end

    assign phase_o = r_phase;
    assign valid_o = r_valid;
    assign busy_o  = (r_state == S_RUN);
    assign done_o  = r_done;
endmodule

// File: tb/tb_sincos_phase_gen.sv
// tb_sincos_phase_gen: scoreboard bench for sincos_phase_gen.
// Expected samples (cycle, phase, done) are queued at stimulus time and popped on valid_o.
module tb_sincos_phase_gen;
    typedef struct {
        int          cyc;
        logic [31:0] ph;
        logic        dn;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_we = 1'b0;
    logic [31:0] cfg_freq = '0;
    logic [31:0] cfg_offset = '0;
    logic [15:0] cfg_div = '0;
    logic [15:0] cfg_burst = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] phase_o;
    logic        valid_o, busy_o, done_o;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    sincos_phase_gen #(.COUNT_WIDTH(16), .DIV_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_freq(cfg_freq),
        .cfg_offset(cfg_offset), .cfg_div(cfg_div), .cfg_burst(cfg_burst),
        .start(start), .stop(stop), .phase_o(phase_o), .valid_o(valid_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic cfg(input logic [31:0] f, input logic [31:0] o, input logic [15:0] d, input logic [15:0] b);
        cfg_freq = f; cfg_offset = o; cfg_div = d; cfg_burst = b; cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if ({phase_o, valid_o, busy_o, done_o} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h/%b/%b/%b want=0/0/0/0", phase_o, valid_o, busy_o, done_o);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        exp_t e;
        cfg(32'h4000_0000, 32'h0, 16'd0, 16'd4);
        q.delete();
        for (int j = 0; j < 4; j++) q.push_back('{j + 2, 32'h4000_0000 * j, j == 3});
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                n_cmp++;
                if (busy_o !== 1'b1) begin n_err++; $display("FAIL basic_busy got=%b want=1", busy_o); end
            end
            if (valid_o) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL basic_extra_valid k=%0d", k); end
                else begin
                    e = q.pop_front();
                    if (k !== e.cyc || phase_o !== e.ph || done_o !== e.dn) begin
                        n_err++;
                        $display("FAIL basic_sample got k=%0d ph=%h dn=%b want k=%0d ph=%h dn=%b", k, phase_o, done_o, e.cyc, e.ph, e.dn);
                    end
                end
            end else begin
                n_cmp++;
                if (done_o !== 1'b0) begin n_err++; $display("FAIL basic_done_stray k=%0d got=%b want=0", k, done_o); end
            end
            if (k == 6) begin
                n_cmp++;
                if (busy_o !== 1'b0) begin n_err++; $display("FAIL basic_busy_end got=%b want=0", busy_o); end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("FAIL basic_missing got=%0d want=0 left", q.size()); end
    endtask

    task automatic test_divider;
        exp_t e;
        cfg(32'h10, 32'h0, 16'd2, 16'd3);
        q.delete();
        for (int j = 0; j < 3; j++) q.push_back('{2 + 3 * j, 32'h10 * j, j == 2});
        start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (valid_o) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL div_extra_valid k=%0d", k); end
                else begin
                    e = q.pop_front();
                    if (k !== e.cyc || phase_o !== e.ph || done_o !== e.dn) begin
                        n_err++;
                        $display("FAIL div_sample got k=%0d ph=%h dn=%b want k=%0d ph=%h dn=%b", k, phase_o, done_o, e.cyc, e.ph, e.dn);
                    end
                end
            end
            if (k == 3) begin
                n_cmp++;
                if (phase_o !== 32'h0) begin n_err++; $display("FAIL div_hold got=%h want=0", phase_o); end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("FAIL div_missing got=%0d want=0 left", q.size()); end
    endtask

    task automatic test_wrap_bypass;
        exp_t e;
        q.delete();
        q.push_back('{2, 32'hFFFF_FFFF, 1'b0});
        q.push_back('{3, 32'h8000_0000, 1'b0});
        q.push_back('{4, 32'h0000_0001, 1'b1});
        cfg_freq = 32'h8000_0001; cfg_offset = 32'hFFFF_FFFF; cfg_div = 16'd0; cfg_burst = 16'd3;
        cfg_we = 1'b1; start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin cfg_we = 1'b0; start = 1'b0; end
            if (valid_o) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL wrap_extra_valid k=%0d", k); end
                else begin
                    e = q.pop_front();
                    if (k !== e.cyc || phase_o !== e.ph || done_o !== e.dn) begin
                        n_err++;
                        $display("FAIL wrap_sample got k=%0d ph=%h dn=%b want k=%0d ph=%h dn=%b", k, phase_o, done_o, e.cyc, e.ph, e.dn);
                    end
                end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("FAIL wrap_missing got=%0d want=0 left", q.size()); end
    endtask

    task automatic test_reconfig;
        exp_t e;
        logic [31:0] ph_tab [7];
        ph_tab = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h400, 32'h600, 32'h800};
        cfg(32'h100, 32'h0, 16'd0, 16'd0);
        q.delete();
        for (int j = 0; j < 7; j++) q.push_back('{j + 2, ph_tab[j], 1'b0});
        start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) begin cfg_freq = 32'h200; cfg_we = 1'b1; end
            if (k == 4) cfg_we = 1'b0;
            if (k == 8) stop = 1'b1;
            if (k == 9) stop = 1'b0;
            n_cmp++;
            if (done_o !== 1'b0) begin n_err++; $display("FAIL reconf_done k=%0d got=%b want=0", k, done_o); end
            if (valid_o) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL reconf_extra_valid k=%0d", k); end
                else begin
                    e = q.pop_front();
                    if (k !== e.cyc || phase_o !== e.ph) begin
                        n_err++;
                        $display("FAIL reconf_sample got k=%0d ph=%h want k=%0d ph=%h", k, phase_o, e.cyc, e.ph);
                    end
                end
            end
        end
        n_cmp++;
        if (q.size() != 0 || busy_o !== 1'b0) begin n_err++; $display("FAIL reconf_end got left=%0d busy=%b want 0/0", q.size(), busy_o); end
    endtask

    task automatic test_stop;
        exp_t e;
        cfg(32'h1000, 32'h55, 16'd1, 16'd10);
        q.delete();
        for (int j = 0; j < 3; j++) q.push_back('{2 + 2 * j, 32'h55 + 32'h1000 * j, 1'b0});
        start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 6) stop = 1'b1;
            if (k == 7) begin
                stop = 1'b0;
                n_cmp++;
                if (busy_o !== 1'b0) begin n_err++; $display("FAIL stop_busy got=%b want=0", busy_o); end
            end
            n_cmp++;
            if (done_o !== 1'b0) begin n_err++; $display("FAIL stop_done k=%0d got=%b want=0", k, done_o); end
            if (valid_o) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL stop_extra_valid k=%0d", k); end
                else begin
                    e = q.pop_front();
                    if (k !== e.cyc || phase_o !== e.ph) begin
                        n_err++;
                        $display("FAIL stop_sample got k=%0d ph=%h want k=%0d ph=%h", k, phase_o, e.cyc, e.ph);
                    end
                end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("FAIL stop_missing got=%0d want=0 left", q.size()); end
        // restart with start+stop together, then stop on the final burst edge
        cfg(32'h1000, 32'h55, 16'd0, 16'd2);
        q.push_back('{2, 32'h55, 1'b0});
        q.push_back('{3, 32'h1055, 1'b1});
        start = 1'b1; stop = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin start = 1'b0; stop = 1'b0; end
            if (k == 2) stop = 1'b1;
            if (k == 3) stop = 1'b0;
            if (valid_o) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL restart_extra_valid k=%0d", k); end
                else begin
                    e = q.pop_front();
                    if (k !== e.cyc || phase_o !== e.ph || done_o !== e.dn) begin
                        n_err++;
                        $display("FAIL restart_sample got k=%0d ph=%h dn=%b want k=%0d ph=%h dn=%b", k, phase_o, done_o, e.cyc, e.ph, e.dn);
                    end
                end
            end
            if (k == 4) begin
                n_cmp++;
                if (busy_o !== 1'b0) begin n_err++; $display("FAIL restart_busy got=%b want=0", busy_o); end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("FAIL restart_missing got=%0d want=0 left", q.size()); end
    endtask

    task automatic test_reset_midrun;
        exp_t        e;
        logic [31:0] f, o;
        cfg(32'h10, 32'h0, 16'd0, 16'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({phase_o, valid_o, busy_o, done_o} !== 35'd0) begin
            n_err++;
            $display("FAIL async_reset got=%h/%b/%b/%b want=0/0/0/0", phase_o, valid_o, busy_o, done_o);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (valid_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got v=%b b=%b want 0/0", valid_o, busy_o); end
        end
        f = 32'h0123_4567;
        o = 32'h89AB_CDEF;
        cfg(f, o, 16'd0, 16'd0);
        q.delete();
        for (int j = 0; j < 1000; j++) q.push_back('{j + 2, o + f * j, 1'b0});
        start = 1'b1;
        for (int k = 1; k <= 1003; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 1001) stop = 1'b1;
            if (k == 1002) stop = 1'b0;
            if (valid_o) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL cont_extra_valid k=%0d", k); end
                else begin
                    e = q.pop_front();
                    if (k !== e.cyc || phase_o !== e.ph || done_o !== 1'b0) begin
                        n_err++;
                        $display("FAIL cont_sample got k=%0d ph=%h dn=%b want k=%0d ph=%h dn=0", k, phase_o, done_o, e.cyc, e.ph);
                    end
                end
            end
        end
        n_cmp++;
        if (q.size() != 0 || busy_o !== 1'b0) begin n_err++; $display("FAIL cont_end got left=%0d busy=%b want 0/0", q.size(), busy_o); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_divider;
        test_wrap_bypass;
        test_reconfig;
        test_stop;
        test_reset_midrun;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
